// File: rtl/psram_define_pkg.sv
// Shared definitions for the PSRAM QPI link: opcodes and the responder FSM state type.
package psram_define_pkg;

    localparam logic [7:0] PSRAM_CMD_QREAD  = 8'hEB;
    localparam logic [7:0] PSRAM_CMD_QWRITE = 8'h38;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_RDATA,
        S_WDATA,
        S_IGNORE
    } psram_state_t;

endpackage

// File: rtl/psram_pin_sync.sv
// Two-flop synchronizer for SCK, CE and IO as one bus so they stay aligned,
// plus single-cycle SCK rise/fall pulses derived from the synchronized clock.
module psram_pin_sync #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         sck_i,
    input  logic         ce_i,
    input  logic [W-1:0] io_i,
    output logic         ce_s_o,
    output logic [W-1:0] io_s_o,
    output logic         rise_o,
    output logic         fall_o
);

    // CE resets to the deselected level so release from reset never looks like a select.
    localparam logic [W+1:0] RST_VAL = {1'b0, 1'b1, {W{1'b0}}};

    logic [W+1:0] r_meta;
    logic [W+1:0] r_sync;
    logic         r_sck_q;
    logic         w_sck_s;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_meta  <= RST_VAL;
            r_sync  <= RST_VAL;
            r_sck_q <= 1'b0;
        end else begin
            r_meta  <= {sck_i, ce_i, io_i};
            r_sync  <= r_meta;
            r_sck_q <= r_sync[W+1];
        end
    end

    assign w_sck_s = r_sync[W+1];
    assign ce_s_o  = r_sync[W];
    assign io_s_o  = r_sync[W-1:0];
    assign rise_o  = w_sck_s & ~r_sck_q;
    assign fall_o  = ~w_sck_s & r_sck_q;

endmodule

// File: rtl/psram_qpi_slave.sv
// QPI PSRAM responder: decodes quad read (0xEB) / quad write (0x38) from oversampled
// SCK/CE/IO and serves them through a byte-wide memory port with 1-clk read latency.
module psram_qpi_slave #(
    parameter int ADDR_WIDTH = 24,
    parameter int DUMMY_CYC  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  psram_sck_i,
    input  logic                  psram_ce_i,
    input  logic [3:0]            psram_io_in_i,
    output logic [3:0]            psram_io_out_o,
    output logic [3:0]            psram_io_en_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    input  logic [7:0]            mem_rdata_i,
    output logic                  cmd_err_o
);

    import psram_define_pkg::*;

    localparam int ADDR_NIB = (ADDR_WIDTH + 3) / 4;
    localparam int SHIFT_W  = ADDR_NIB * 4;
    localparam int CNT_MAX  = (DUMMY_CYC > ADDR_NIB) ? DUMMY_CYC : ADDR_NIB;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_NIB - 1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYC - 1);

    logic                  w_ce_s;
    logic [3:0]            w_io_s;
    logic                  w_rise;
    logic                  w_fall;
    logic [SHIFT_W-1:0]    w_shift_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_in;
    logic [7:0]            w_rd_byte;

    psram_state_t          r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [SHIFT_W-1:0]    r_shift;
    logic                  r_is_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_wnib;
    logic [7:0]            r_rd_buf;
    logic                  r_rd_pend;
    logic [7:0]            r_dshift;
    logic                  r_phase;
    logic [3:0]            r_io_out;
    logic [3:0]            r_io_en;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_mem_wdata;
    logic                  r_cmd_err;

    psram_pin_sync #(.W(4)) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .sck_i   (psram_sck_i),
        .ce_i    (psram_ce_i),
        .io_i    (psram_io_in_i),
        .ce_s_o  (w_ce_s),
        .io_s_o  (w_io_s),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    assign w_shift_nxt = {r_shift[SHIFT_W-5:0], w_io_s};
    assign w_addr_in   = w_shift_nxt[ADDR_WIDTH-1:0];
    // Forward the memory response when it arrives on the same clk as the fall that needs it.
    assign w_rd_byte   = r_rd_pend ? mem_rdata_i : r_rd_buf;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_is_wr     <= 1'b0;
            r_addr      <= '0;
            r_wnib      <= '0;
            r_rd_buf    <= '0;
            r_rd_pend   <= 1'b0;
            r_dshift    <= '0;
            r_phase     <= 1'b0;
            r_io_out    <= '0;
            r_io_en     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_mem_req <= 1'b0;
            r_cmd_err <= 1'b0;
            r_rd_pend <= r_mem_req & ~r_mem_we;
            if (r_rd_pend && !w_ce_s) begin
                r_rd_buf <= mem_rdata_i;
            end

            if (w_ce_s && (r_state != S_IDLE)) begin
                r_state   <= S_IDLE;
                r_io_en   <= '0;
                r_io_out  <= '0;
                r_rd_pend <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_ce_s) begin
                            r_state <= S_CMD;
                            r_cnt   <= '0;
                        end
                    end

                    S_CMD: begin
                        if (w_rise) begin
                            r_shift <= w_shift_nxt;
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_cnt == CNT_W'(1)) begin
                                r_cnt <= '0;
                                case (w_shift_nxt[7:0])
                                    PSRAM_CMD_QREAD: begin
                                        r_is_wr <= 1'b0;
                                        r_state <= S_ADDR;
                                    end
                                    PSRAM_CMD_QWRITE: begin
                                        r_is_wr <= 1'b1;
                                        r_state <= S_ADDR;
                                    end
                                    default: begin
                                        r_cmd_err <= 1'b1;
                                        r_state   <= S_IGNORE;
                                    end
                                endcase
                            end
                        end
                    end

                    S_ADDR: begin
                        if (w_rise) begin
                            r_shift <= w_shift_nxt;
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_cnt == ADDR_LAST) begin
                                r_cnt  <= '0;
                                r_addr <= w_addr_in;
                                if (r_is_wr) begin
                                    r_state <= S_WDATA;
                                end else begin
                                    r_mem_req  <= 1'b1;
                                    r_mem_we   <= 1'b0;
                                    r_mem_addr <= w_addr_in;
                                    r_phase    <= 1'b0;
                                    r_state    <= (DUMMY_CYC == 0) ? S_RDATA : S_DUMMY;
                                end
                            end
                        end
                    end

                    S_DUMMY: begin
                        if (w_rise) begin
                            if (r_cnt == DUMMY_LAST) begin
                                r_cnt   <= '0;
                                r_state <= S_RDATA;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end

                    S_RDATA: begin
                        if (w_fall) begin
                            r_phase <= ~r_phase;
                            if (!r_phase) begin
                                // High nibble: consume the prefetched byte and fetch the next one.
                                r_dshift   <= w_rd_byte;
                                r_io_out   <= w_rd_byte[7:4];
                                r_io_en    <= 4'hF;
                                r_addr     <= r_addr + 1'b1;
                                r_mem_req  <= 1'b1;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= r_addr + 1'b1;
                            end else begin
                                r_io_out <= r_dshift[3:0];
                            end
                        end
                    end

                    S_WDATA: begin
                        if (w_rise) begin
                            if (r_cnt == '0) begin
                                r_wnib <= w_io_s;
                                r_cnt  <= CNT_W'(1);
                            end else begin
                                r_cnt       <= '0;
                                r_mem_req   <= 1'b1;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= r_addr;
                                r_mem_wdata <= {r_wnib, w_io_s};
                                r_addr      <= r_addr + 1'b1;
                            end
                        end
                    end

                    S_IGNORE: begin
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign psram_io_out_o = r_io_out;
    assign psram_io_en_o  = r_io_en;
    assign mem_req_o      = r_mem_req;
    assign mem_we_o       = r_mem_we;
    assign mem_addr_o     = r_mem_addr;
    assign mem_wdata_o    = r_mem_wdata;
    assign cmd_err_o      = r_cmd_err;

endmodule

// File: tb/tb_psram_qpi_slave.sv
// Bench for psram_qpi_slave: acts as the QPI controller and as the byte memory behind the responder.
module tb_psram_qpi_slave;

    localparam int AW = 24;
    localparam int DC = 6;
    localparam int H  = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sck = 1'b0;
    logic          ce = 1'b1;
    logic [3:0]    io_in = 4'h0;
    logic [3:0]    io_out;
    logic [3:0]    io_en;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'h00;
    logic          cmd_err;

    always #5 clk = ~clk;

    psram_qpi_slave #(.ADDR_WIDTH(AW), .DUMMY_CYC(DC)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .psram_sck_i    (sck),
        .psram_ce_i     (ce),
        .psram_io_in_i  (io_in),
        .psram_io_out_o (io_out),
        .psram_io_en_o  (io_en),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .cmd_err_o      (cmd_err)
    );

    // Reference memory, indexed by byte address; written by the test from expected values.
    logic [7:0] mem [int];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t wr_q[$];
    int  n_req = 0;
    int  n_err = 0;
    int  checks = 0;
    int  failures = 0;

    function automatic logic [7:0] mget(input int k);
        return mem.exists(k) ? mem[k] : 8'h00;
    endfunction

    function automatic int wrap(input logic [AW-1:0] a, input int i);
        return (int'(a) + i) % (1 << AW);
    endfunction

    always @(posedge clk) begin
        if (mem_req) begin
            n_req <= n_req + 1;
            if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
            else        mem_rdata <= mget(int'(mem_addr));
        end
        if (cmd_err) n_err <= n_err + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic nib_out(input logic [3:0] v);
        io_in = v;
        tick(H);
        sck = 1'b1;
        tick(H);
        sck = 1'b0;
    endtask

    task automatic byte_out(input logic [7:0] b);
        nib_out(b[7:4]);
        nib_out(b[3:0]);
    endtask

    task automatic nib_in(output logic [3:0] v, output logic [3:0] en);
        tick(H);
        v  = io_out;
        en = io_en;
        sck = 1'b1;
        tick(H);
        sck = 1'b0;
    endtask

    task automatic hdr(input logic [7:0] op, input logic [AW-1:0] a);
        ce = 1'b0;
        byte_out(op);
        for (int i = 0; i < 6; i++) nib_out(a[23-4*i -: 4]);
    endtask

    task automatic desel();
        tick(H);
        ce = 1'b1;
        io_in = 4'h0;
        tick(4 * H);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input int n, input logic [7:0] d [8], input string tag);
        int base;
        base = n_req;
        wr_q.delete();
        hdr(8'h38, a);
        for (int i = 0; i < n; i++) byte_out(d[i]);
        desel();
        check({tag, " nreq"}, 32'(n_req - base), 32'(n));
        check({tag, " nwr"}, 32'(wr_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < wr_q.size()) begin
                check({tag, " waddr"}, 32'(wr_q[i].a), 32'(wrap(a, i)));
                check({tag, " wdata"}, 32'(wr_q[i].d), 32'(d[i]));
            end
            mem[wrap(a, i)] = d[i];
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int n, input logic [7:0] e [8], input string tag);
        logic [3:0] hi, lo, eh, el;
        hdr(8'hEB, a);
        for (int i = 0; i < DC; i++) begin
            nib_in(hi, eh);
            check({tag, " dummy en"}, 32'(eh), 32'h0);
        end
        for (int i = 0; i < n; i++) begin
            nib_in(hi, eh);
            nib_in(lo, el);
            check({tag, " rdata"}, 32'({hi, lo}), 32'(e[i]));
            check({tag, " data en"}, 32'({eh, el}), 32'hFF);
        end
        desel();
        check({tag, " en after ce"}, 32'(io_en), 32'h0);
    endtask

    typedef struct {
        logic [7:0]    op;
        logic [AW-1:0] addr;
        int            n;
        logic [7:0]    b0;
        logic [7:0]    b1;
        int            exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] d [8];
        logic [3:0] v, en;
        int base, ebase;

        vecs[0] = '{8'h38, 24'h000010, 2, 8'hA5, 8'h3C, 0};
        vecs[1] = '{8'hEB, 24'h000010, 2, 8'hA5, 8'h3C, 0};
        vecs[2] = '{8'h38, 24'hFFFFFF, 2, 8'h5A, 8'hC3, 0};
        vecs[3] = '{8'hEB, 24'hFFFFFF, 2, 8'h5A, 8'hC3, 0};
        vecs[4] = '{8'h9F, 24'h000000, 0, 8'h00, 8'h00, 1};
        vecs[5] = '{8'hEB, 24'h000011, 1, 8'h3C, 8'h00, 0};

        tick(3);
        check("rst io_en", 32'(io_en), 32'h0);
        check("rst io_out", 32'(io_out), 32'h0);
        check("rst mem_req", 32'(mem_req), 32'h0);
        check("rst mem_we", 32'(mem_we), 32'h0);
        check("rst mem_addr", 32'(mem_addr), 32'h0);
        check("rst mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst cmd_err", 32'(cmd_err), 32'h0);
        rst_n = 1'b1;
        tick(5);

        for (int k = 0; k < 6; k++) begin
            d[0] = vecs[k].b0;
            d[1] = vecs[k].b1;
            if (vecs[k].op == 8'h38) begin
                do_write(vecs[k].addr, vecs[k].n, d, $sformatf("vec%0d", k));
            end else if (vecs[k].op == 8'hEB) begin
                do_read(vecs[k].addr, vecs[k].n, d, $sformatf("vec%0d", k));
            end else begin
                base  = n_req;
                ebase = n_err;
                ce = 1'b0;
                byte_out(vecs[k].op);
                for (int i = 0; i < 4; i++) begin
                    nib_in(v, en);
                    check("badop en", 32'(en), 32'h0);
                end
                desel();
                check("badop err", 32'(n_err - ebase), 32'(vecs[k].exp_err));
                check("badop nreq", 32'(n_req - base), 32'h0);
            end
        end

        // Abort after a single write nibble: nothing reaches memory, next write is normal.
        base = n_req;
        wr_q.delete();
        hdr(8'h38, 24'h000020);
        nib_out(4'h7);
        desel();
        check("abort nreq", 32'(n_req - base), 32'h0);
        check("abort nwr", 32'(wr_q.size()), 32'h0);
        d[0] = 8'h96;
        do_write(24'h000020, 1, d, "after abort");
        d[0] = 8'h96;
        do_read(24'h000020, 1, d, "after abort rd");

        // Reset in the middle of a read burst.
        hdr(8'hEB, 24'h000010);
        for (int i = 0; i < DC + 2; i++) nib_in(v, en);
        check("pre-rst en", 32'(en), 32'hF);
        rst_n = 1'b0;
        #1;
        check("midrst en", 32'(io_en), 32'h0);
        check("midrst req", 32'(mem_req), 32'h0);
        check("midrst out", 32'(io_out), 32'h0);
        sck = 1'b0;
        ce = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4 * H);
        d[0] = 8'hA5;
        d[1] = 8'h3C;
        do_read(24'h000010, 2, d, "post rst rd");

        // Random bursts against the reference memory, biased toward the wrap point.
        for (int it = 0; it < 20; it++) begin
            logic [AW-1:0] a;
            int n;
            a = ($urandom_range(0, 3) == 0) ? (24'hFFFFFF - 24'($urandom_range(0, 2)))
                                            : 24'($urandom_range(0, 63));
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) d[i] = 8'($urandom);
                do_write(a, n, d, "rnd wr");
            end else begin
                for (int i = 0; i < n; i++) d[i] = mget(wrap(a, i));
                do_read(a, n, d, "rnd rd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
